// File: rtl/aes_decrypt_sequencer.sv
// -----------------------------------------------------------------------------
// aes_decrypt_sequencer
//   Iterative AES-128 decryption: one round per clock, with round keys fetched
//   from an external combinational key store.
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     in_valid   ciphertext block offered
//     in_ready   sequencer can accept a block (IDLE only)
//     in         128-bit ciphertext, byte 0 in [127:120], column-major
//     key_addr   round-key index requested from the key store (0..10)
//     key_in     round key for key_addr, valid in the same cycle
//     out_valid  plaintext available (DONE only)
//     out_ready  consumer accepts out
//     out        128-bit plaintext, driven straight from the state register
//     busy       a block is in flight
//
//   Timing: transfer cycle -> 9 ROUND cycles (keys 9..1) -> 1 FINAL cycle
//   (key 0) -> DONE, held until out_ready is sampled high.
// -----------------------------------------------------------------------------
module aes_decrypt_sequencer (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  output logic [3:0]   key_addr,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // ---------------------------------------------------------------------------
  // Round primitives. Byte i of the block lives at [127-8*i -: 8]; byte i is
  // row (i % 4), column (i / 4).
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int unsigned i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return r;
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*(((c+4)-w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   m11 [4];
    logic [7:0]   m13 [4];
    logic [7:0]   m14 [4];
    logic [7:0]   x2, x4, x8;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned w = 0; w < 4; w++) begin
        a[w]   = s[127-8*(4*c+w) -: 8];
        x2     = xt(a[w]);
        x4     = xt(x2);
        x8     = xt(x4);
        m9[w]  = x8 ^ a[w];
        m11[w] = x8 ^ x2 ^ a[w];
        m13[w] = x8 ^ x4 ^ a[w];
        m14[w] = x8 ^ x4 ^ x2;
      end
      r[127-8*(4*c+0) -: 8] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
      r[127-8*(4*c+1) -: 8] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
      r[127-8*(4*c+2) -: 8] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
      r[127-8*(4*c+3) -: 8] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (in_valid)          fsm_d = ROUND;
      ROUND:   if (round_q == 4'd1)   fsm_d = FINAL;
      FINAL:                          fsm_d = DONE;
      DONE:    if (out_ready)         fsm_d = IDLE;
      default:                        fsm_d = IDLE;
    endcase
  end

  // Datapath: in and key_in are consumed only on the IDLE transfer and in the
  // ROUND/FINAL cycles; everywhere else the state register holds.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in ^ key_in;
          round_d = 4'd9;
        end
      end
      ROUND: begin
        state_d = inv_mix_columns(inv_shift_rows(inv_sub_bytes(state_q)) ^ key_in);
        round_d = round_q - 4'd1;
      end
      FINAL: begin
        state_d = inv_sub_bytes(inv_shift_rows(state_q)) ^ key_in;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (fsm_q == IDLE);
    busy      = (fsm_q != IDLE);
    out_valid = (fsm_q == DONE);
    out       = state_q;
    unique case (fsm_q)
      ROUND:   key_addr = round_q;
      FINAL:   key_addr = 4'd0;
      default: key_addr = 4'd10;  // IDLE (and DONE) pre-present the first key
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_sequencer
//   Directed bench for aes_decrypt_sequencer. The key store is a bench-side
//   AES-128 key expansion computed from the cipher keys (forward S-box derived
//   from the GF(2^8) inverse and affine map), indexed combinationally by
//   key_addr. Known-answer ciphertext/plaintext pairs come from FIPS-197 and
//   SP 800-38A.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_i;
  logic [3:0]   key_addr;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_o;
  logic         busy;

  always #5 clk = ~clk;

  aes_decrypt_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_i),
    .key_addr  (key_addr),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_o),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Key store
  // ---------------------------------------------------------------------------
  logic [127:0] rk [3][11];
  int           ks_sel;

  assign key_in = (key_addr <= 4'd10) ? rk[ks_sel][key_addr] : '0;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, x);  // x^254 = x^-1 (0 -> 0)
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input int slot, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[slot][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  // Called at the negedge just after the transfer edge; walks ROUND x9 and
  // FINAL, then leaves the bench at the first DONE negedge.
  task automatic finish_block(input logic [127:0] pt, input bit scramble);
    for (int k = 9; k >= 0; k--) begin
      chk("key_addr_seq", key_addr, k);
      chk("out_valid_early", out_valid, 0);
      chk("busy_inflight", busy, 1);
      if (scramble && k == 9) in_i = ~in_i;
      step();
    end
    chk("latency_out_valid", out_valid, 1);
    chk("plaintext", out_o, pt);
    chk("in_ready_done", in_ready, 0);
  endtask

  task automatic run_vector(input int slot, input logic [127:0] ct,
                            input logic [127:0] pt, input bit scramble);
    ks_sel    = slot;
    in_i      = ct;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    chk("key_addr_idle", key_addr, 10);
    step();
    in_valid = 1'b0;
    finish_block(pt, scramble);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_key_addr", key_addr, 10);
  endtask

  typedef struct {
    int           slot;
    logic [127:0] ct;
    logic [127:0] pt;
    bit           scramble;
  } vec_t;

  vec_t vecs [6];

  int          acc [2];
  logic [127:0] outs [2];
  int          nacc, nout;
  bit          found;

  initial begin
    vecs[0] = '{0, C1_CT, C1_PT, 1'b0};
    vecs[1] = '{1, B_CT, B_PT, 1'b0};
    vecs[2] = '{1, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b0};
    vecs[3] = '{1, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0};
    vecs[4] = '{2, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 1'b0};
    vecs[5] = '{0, C1_CT, C1_PT, 1'b1};

    expand(0, 128'h000102030405060708090a0b0c0d0e0f);
    expand(1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    expand(2, 128'h0);

    // Reset with in_valid already high: block must be taken on the first
    // cycle reset is low.
    ks_sel    = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_i      = C1_CT;
    out_ready = 1'b1;
    @(negedge clk);
    step();
    chk("keystore_round10", rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_addr", key_addr, 10);
    chk("rst_state", out_o, 0);
    reset = 1'b0;
    step();
    in_valid = 1'b0;
    chk("first_accept_busy", busy, 1);
    finish_block(C1_PT, 1'b0);
    step();
    chk("first_idle", busy, 0);

    // Table of known-answer vectors.
    foreach (vecs[i]) run_vector(vecs[i].slot, vecs[i].ct, vecs[i].pt, vecs[i].scramble);

    // Backpressure in DONE, with a competing in_valid.
    ks_sel    = 0;
    in_i      = C1_CT;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    finish_block(C1_PT, 1'b0);
    in_valid = 1'b1;
    in_i     = B_CT;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_stable", out_o, C1_PT);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    chk("bp_still_done", out_valid, 1);
    chk("bp_out_after", out_o, C1_PT);
    out_ready = 1'b1;
    step();
    chk("bp_release_idle", busy, 0);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    in_valid = 1'b0;
    step();
    chk("bp_no_accept", busy, 0);

    // Back-to-back with in_valid held high; second block is C.1.
    ks_sel    = 1;
    in_i      = B_CT;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    nacc      = 0;
    nout      = 0;
    for (int c = 0; c < 60 && nout < 2; c++) begin
      if (in_valid && in_ready && nacc < 2) begin
        acc[nacc] = c;
        nacc++;
      end
      if (out_valid) begin
        outs[nout] = out_o;
        nout++;
        if (nout == 1) ks_sel = 0;
      end
      step();
      if (nacc == 1) in_i = C1_CT;
      if (nacc == 2) in_valid = 1'b0;
    end
    chk("b2b_accepts", nacc, 2);
    chk("b2b_outputs", nout, 2);
    if (nacc == 2) chk("b2b_spacing", acc[1] - acc[0], 12);
    if (nout == 2) begin
      chk("b2b_out0", outs[0], B_PT);
      chk("b2b_out1", outs[1], C1_PT);
    end
    in_valid = 1'b0;
    step();

    // Reset while in ROUND at round 5.
    ks_sel   = 0;
    in_i     = C1_CT;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (key_addr == 4'd5 && busy) found = 1'b1;
      else step();
    end
    chk("midrst_reach_round5", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_state", out_o, 0);
    chk("midrst_key_addr", key_addr, 10);
    step();
    chk("midrst_no_pulse", out_valid, 0);
    run_vector(0, C1_CT, C1_PT, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d vectors applied", nvec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_decrypt_sequencer.md
AES_DECRYPT_SEQUENCER -- requirements
Module: aes_decrypt_sequencer

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
  clk  input  1  single clock; all state updates on rising edge
  reset  input  1  synchronous, active-high reset
  in_valid  input  1  ciphertext block offered
  in_ready  output  1  sequencer can accept a block
  in  input  128  ciphertext block; byte 0 in [127:120], FIPS-197 column-major
  key_addr  output  4  round-key index requested, 0..10
  key_in  input  128  round key for key_addr, valid in the same cycle (combinational external key store)
  out_valid  output  1  plaintext block available
  out_ready  input  1  consumer accepts out
  out  output  128  plaintext block, same byte order as in
  busy  output  1  block in flight (any state other than IDLE)
REQ-002 The clock SHALL be named clk and the reset SHALL be named reset. Reset SHALL be synchronous and active-high.
REQ-003 The block SHALL have no parameters. Key width is fixed at 128 bits and the round count at 10.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, ROUND, FINAL and DONE, a 128-bit state register and a 4-bit round counter.
REQ-005 in_ready SHALL be 1 only in IDLE. A transfer SHALL occur on a cycle with in_valid && in_ready.
REQ-006 In IDLE, key_addr SHALL be 10.
REQ-007 On an IDLE transfer, the block SHALL load state <= in ^ key_in, set round <= 9 and go to ROUND.
REQ-008 In ROUND, key_addr SHALL equal round.
REQ-009 In ROUND, each cycle the block SHALL apply the team's Decryption_Round datapath with key_in, in this order: InvSubBytes, InverseShiftRows, AddRoundKey, InvMixColumns. The result SHALL be written to state.
REQ-010 In ROUND, round SHALL decrement by 1 each cycle. When round==1, the next state SHALL be FINAL.
REQ-011 In FINAL, key_addr SHALL be 0.
REQ-012 In FINAL, the block SHALL compute state <= InvSubBytes(InverseShiftRows(state)) ^ key_in, with no InvMixColumns, and go to DONE.
REQ-013 In DONE, out_valid SHALL be 1 and out SHALL equal state. Both SHALL hold stable until out_ready is sampled high.
REQ-014 In DONE with out_ready=1, the block SHALL return to IDLE. No new block SHALL be accepted in that same cycle.
REQ-015 Latency: out_valid SHALL rise exactly 10 cycles after the transfer cycle, which is 9 ROUND cycles plus 1 FINAL cycle.
REQ-016 Minimum spacing between accepted blocks SHALL be 12 cycles when out_ready is held at 1.
REQ-017 out SHALL be driven directly from the state register in every state. Its value is meaningful only while out_valid=1.
REQ-018 in and key_in SHALL be ignored in every state except where REQ-007, REQ-009 and REQ-012 use them. Changing in after acceptance SHALL NOT affect the result.
REQ-019 in_valid asserted in ROUND, FINAL or DONE SHALL have no effect. The block SHALL NOT queue it.
REQ-020 out_ready asserted outside DONE SHALL have no effect.
REQ-021 key_addr SHALL be a pure function of state and round (registered-state decode). It SHALL NOT depend combinationally on in_valid or out_ready.
REQ-022 busy SHALL be 1 in ROUND, FINAL and DONE, and 0 in IDLE.

Reset
REQ-023 When reset=1 at a rising edge, the next state SHALL be IDLE, with state=0, round=0, out_valid=0, busy=0, in_ready=1 and key_addr=10.
REQ-024 Reset SHALL take priority over every other input in any state, including mid-ROUND and DONE. Any in-flight block SHALL be discarded with no out_valid pulse.
REQ-025 The first transfer after reset SHALL be accepted in the first cycle with reset=0 and in_valid=1.

Verification
REQ-026 FIPS-197 C.1 vector: bench key store holds the expansion of key 000102030405060708090a0b0c0d0e0f (round 10 = 13111d7fe3944a17f307a78b4d2b30c5). Stimulus: in=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1. Required: out=00112233445566778899aabbccddeeff with out_valid 10 cycles after the transfer.
REQ-027 key_addr sequence: for that vector, key_addr per cycle from the transfer cycle SHALL read 10,9,8,7,6,5,4,3,2,1,0, then 10 once back in IDLE.
REQ-028 Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: out_valid=1 and out constant throughout, in_ready=0, and a new in_valid is ignored. Raising out_ready SHALL return the block to IDLE on the next edge.
REQ-029 Back-to-back: two blocks with in_valid held high, the second being the C.1 ciphertext again. Required: second accepted exactly 12 cycles after the first, and both outputs correct.
REQ-030 Reset mid-operation: assert reset in ROUND at round=5. Required: IDLE, out_valid=0, state=0 on the next cycle. A following C.1 transfer SHALL decrypt correctly.
REQ-031 in change: alter in on the cycle after acceptance. Required: output unaffected (still 00112233445566778899aabbccddeeff).
